// File: rtl/ft245_interface_pkg.sv
// Shared FT245 timing constants, FSM state encoding and the ns-to-cycles helper.
package ft245_interface_pkg;

  localparam int T_RD_NS    = 50;
  localparam int T_RDREC_NS = 50;
  localparam int T_SETUP_NS = 20;
  localparam int T_WR_NS    = 50;
  localparam int T_HOLD_NS  = 10;

  typedef enum logic [2:0] {
    IDLE,
    RD_PULSE,
    RD_RECOVER,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  // Rounds up so every strobe is at least as long as the device requires.
  function automatic int ns_to_cycles(input int ns, input int period_ns);
    int c;
    c = (ns + period_ns - 1) / period_ns;
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/ft245_interface_sync_2ff.sv
// Single-bit two-flop synchronizer; resets to 1 so the active-low flags idle inactive.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ft245_interface.sv
// FT245 FIFO bridge: paces RD#/WR strobes from the clock period and hands bytes
// to/from a ready/ack stream interface.
module ft245_interface
  import ft245_interface_pkg::*;
#(
  parameter int CLOCK_PERIOD_NS = 10,
  parameter int DATA_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data_245,
  input  logic                  rxf_245,
  output logic                  rx_245,
  output logic [DATA_WIDTH-1:0] tx_data_245,
  input  logic                  txe_245,
  output logic                  wr_245,
  output logic                  tx_oe_245,
  output logic [DATA_WIDTH-1:0] rx_data_si,
  output logic                  rx_rdy_si,
  input  logic                  rx_ack_si,
  input  logic [DATA_WIDTH-1:0] tx_data_si,
  input  logic                  tx_rdy_si,
  output logic                  tx_ack_si
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(ns_to_cycles(T_RD_NS,    CLOCK_PERIOD_NS) - 1);
  localparam logic [CNT_W-1:0] RDREC_LAST = CNT_W'(ns_to_cycles(T_RDREC_NS, CLOCK_PERIOD_NS) - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(ns_to_cycles(T_SETUP_NS, CLOCK_PERIOD_NS) - 1);
  localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(ns_to_cycles(T_WR_NS,    CLOCK_PERIOD_NS) - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(ns_to_cycles(T_HOLD_NS,  CLOCK_PERIOD_NS) - 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic             rxf_s, txe_s;
  logic             rd_req, wr_req;
  logic             last_wr;
  logic             start_rd, start_wr, rd_done;

  sync_2ff u_sync_rxf (.clk(clk), .rst(rst), .d(rxf_245), .q(rxf_s));
  sync_2ff u_sync_txe (.clk(clk), .rst(rst), .d(txe_245), .q(txe_s));

  assign rd_req   = !rxf_s && !rx_rdy_si;
  assign wr_req   = !txe_s && tx_rdy_si;
  assign start_rd = (state == IDLE) && (next_state == RD_PULSE);
  assign start_wr = (state == IDLE) && (next_state == WR_SETUP);
  assign rd_done  = (state == RD_PULSE) && (next_state == RD_RECOVER);

  // State register; the counter restarts on every state change and idles at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (next_state != state || state == IDLE) cnt <= '0;
      else                                       cnt <= cnt + 1'b1;
    end
  end

  // Under contention the direction not served last wins; last_wr resets high.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (rd_req && (!wr_req || last_wr)) next_state = RD_PULSE;
        else if (wr_req)                    next_state = WR_SETUP;
      end
      RD_PULSE:   if (cnt == RD_LAST)    next_state = RD_RECOVER;
      RD_RECOVER: if (cnt == RDREC_LAST) next_state = IDLE;
      WR_SETUP:   if (cnt == SETUP_LAST) next_state = WR_PULSE;
      WR_PULSE:   if (cnt == WR_LAST)    next_state = WR_HOLD;
      WR_HOLD:    if (cnt == HOLD_LAST)  next_state = IDLE;
      default:                           next_state = IDLE;
    endcase
  end

  always_comb begin
    rx_245    = (state != RD_PULSE);
    wr_245    = (state == WR_PULSE);
    tx_oe_245 = (state == WR_SETUP) || (state == WR_PULSE) || (state == WR_HOLD);
  end

  // Byte capture and handshakes; rx_data_245 is sampled at the end of the last RD# low cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_si  <= '0;
      rx_rdy_si   <= 1'b0;
      tx_data_245 <= '0;
      tx_ack_si   <= 1'b0;
      last_wr     <= 1'b1;
    end else begin
      tx_ack_si <= start_wr;
      if (rd_done) begin
        rx_data_si <= rx_data_245;
        rx_rdy_si  <= 1'b1;
      end else if (rx_rdy_si && rx_ack_si) begin
        rx_rdy_si  <= 1'b0;
      end
      if (start_wr) begin
        tx_data_245 <= tx_data_si;
        last_wr     <= 1'b1;
      end else if (start_rd) begin
        last_wr     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ft245_interface.sv
// Self-checking bench for ft245_interface: scenario tasks plus a byte scoreboard.
module tb_ft245_interface;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data_245 = 8'h00;
  logic       rxf_245 = 1'b1;
  logic       rx_245;
  logic [7:0] tx_data_245;
  logic       txe_245 = 1'b1;
  logic       wr_245;
  logic       tx_oe_245;
  logic [7:0] rx_data_si;
  logic       rx_rdy_si;
  logic       rx_ack_si = 1'b0;
  logic [7:0] tx_data_si = 8'h00;
  logic       tx_rdy_si = 1'b0;
  logic       tx_ack_si;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp_b;
  logic       prev_rdy = 1'b0;
  logic       prev_wr  = 1'b0;

  ft245_interface #(.CLOCK_PERIOD_NS(10), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .rx_data_245(rx_data_245), .rxf_245(rxf_245), .rx_245(rx_245),
    .tx_data_245(tx_data_245), .txe_245(txe_245), .wr_245(wr_245), .tx_oe_245(tx_oe_245),
    .rx_data_si(rx_data_si), .rx_rdy_si(rx_rdy_si), .rx_ack_si(rx_ack_si),
    .tx_data_si(tx_data_si), .tx_rdy_si(tx_rdy_si), .tx_ack_si(tx_ack_si)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: received bytes pop on rx_rdy_si rising, sent bytes pop on the WR falling edge.
  always @(negedge clk) begin
    if (rx_245 === 1'b0) begin
      checks++;
      if (tx_oe_245 !== 1'b0) begin
        errors++;
        $display("FAIL bus_exclusive tx_oe_245=%b while rx_245=0", tx_oe_245);
      end
    end
    if (!rst && rx_rdy_si === 1'b1 && !prev_rdy) begin
      checks++;
      if (rx_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected got %h with nothing expected", rx_data_si);
      end else begin
        exp_b = rx_q.pop_front();
        if (rx_data_si !== exp_b) begin
          errors++;
          $display("FAIL rx_byte got %h expected %h", rx_data_si, exp_b);
        end
      end
    end
    if (!rst && prev_wr && wr_245 === 1'b0) begin
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected latched %h with nothing expected", tx_data_245);
      end else begin
        exp_b = tx_q.pop_front();
        if (tx_data_245 !== exp_b) begin
          errors++;
          $display("FAIL tx_byte latched %h expected %h", tx_data_245, exp_b);
        end
      end
    end
    prev_rdy = (rx_rdy_si === 1'b1);
    prev_wr  = (wr_245 === 1'b1);
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (rx_245 !== 1'b1)       begin errors++; $display("FAIL reset_rx_245 got %b expected 1", rx_245); end
    checks++; if (wr_245 !== 1'b0)       begin errors++; $display("FAIL reset_wr_245 got %b expected 0", wr_245); end
    checks++; if (tx_oe_245 !== 1'b0)    begin errors++; $display("FAIL reset_tx_oe got %b expected 0", tx_oe_245); end
    checks++; if (tx_data_245 !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h expected 00", tx_data_245); end
    checks++; if (rx_data_si !== 8'h00)  begin errors++; $display("FAIL reset_rx_data got %h expected 00", rx_data_si); end
    checks++; if (rx_rdy_si !== 1'b0)    begin errors++; $display("FAIL reset_rx_rdy got %b expected 0", rx_rdy_si); end
    checks++; if (tx_ack_si !== 1'b0)    begin errors++; $display("FAIL reset_tx_ack got %b expected 0", tx_ack_si); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read();
    int n;
    int low;
    rx_ack_si = 1'b1;
    tick();
    rx_ack_si = 1'b0;
    checks++; if (rx_rdy_si !== 1'b0) begin errors++; $display("FAIL stray_ack rx_rdy got %b expected 0", rx_rdy_si); end
    rx_data_245 = 8'hA5;
    rx_q.push_back(8'hA5);
    rxf_245 = 1'b0;
    for (n = 0; n < 20 && rx_245 !== 1'b0; n++) tick();
    checks++;
    if (rx_245 !== 1'b0) begin errors++; $display("FAIL read_start rx_245 got %b expected 0 within 20 cycles", rx_245); end
    rxf_245 = 1'b1;
    low = 0;
    while (rx_245 === 1'b0 && low < 20) begin low++; tick(); end
    checks++; if (low != 5) begin errors++; $display("FAIL read_strobe_len got %0d expected 5", low); end
    checks++; if (rx_rdy_si !== 1'b1 || rx_data_si !== 8'hA5) begin
      errors++; $display("FAIL read_data rdy=%b data=%h expected rdy=1 data=a5", rx_rdy_si, rx_data_si);
    end
    repeat (10) tick();
    checks++; if (rx_rdy_si !== 1'b1 || rx_data_si !== 8'hA5) begin
      errors++; $display("FAIL read_hold rdy=%b data=%h expected rdy=1 data=a5", rx_rdy_si, rx_data_si);
    end
    rx_ack_si = 1'b1;
    tick();
    rx_ack_si = 1'b0;
    checks++; if (rx_rdy_si !== 1'b0) begin errors++; $display("FAIL read_ack_clear rdy got %b expected 0", rx_rdy_si); end
    repeat (8) tick();
  endtask

  task automatic test_write();
    int n;
    int ack_cnt, wr_cnt, oe_cnt, first_wr, oe_last;
    int bad_data;
    tx_data_si = 8'h3C;
    tx_rdy_si  = 1'b1;
    tx_q.push_back(8'h3C);
    txe_245 = 1'b0;
    for (n = 0; n < 20 && tx_ack_si !== 1'b1; n++) tick();
    checks++;
    if (tx_ack_si !== 1'b1) begin errors++; $display("FAIL write_ack tx_ack got %b expected 1 within 20 cycles", tx_ack_si); end
    tx_rdy_si  = 1'b0;
    tx_data_si = 8'hFF;
    txe_245    = 1'b1;
    ack_cnt = 0; wr_cnt = 0; oe_cnt = 0; first_wr = -1; oe_last = -1; bad_data = 0;
    for (int i = 0; i < 12; i++) begin
      if (tx_ack_si === 1'b1) ack_cnt++;
      if (wr_245 === 1'b1) begin wr_cnt++; if (first_wr < 0) first_wr = i; end
      if (tx_oe_245 === 1'b1) begin
        oe_cnt++; oe_last = i;
        if (tx_data_245 !== 8'h3C) bad_data++;
      end
      tick();
    end
    checks++; if (ack_cnt != 1)  begin errors++; $display("FAIL write_ack_pulses got %0d expected 1", ack_cnt); end
    checks++; if (first_wr != 2) begin errors++; $display("FAIL write_setup wr rose at %0d expected 2", first_wr); end
    checks++; if (wr_cnt != 5)   begin errors++; $display("FAIL write_pulse_len got %0d expected 5", wr_cnt); end
    checks++; if (oe_cnt != 8 || oe_last != 7) begin
      errors++; $display("FAIL write_oe_window len=%0d last=%0d expected len=8 last=7", oe_cnt, oe_last);
    end
    checks++; if (bad_data != 0) begin errors++; $display("FAIL write_data_stable bad_cycles=%0d expected 0", bad_data); end
  endtask

  task automatic test_rx_backpressure();
    int n;
    int low;
    rx_data_245 = 8'h5A;
    rx_q.push_back(8'h5A);
    rxf_245 = 1'b0;
    for (n = 0; n < 40 && rx_rdy_si !== 1'b1; n++) tick();
    checks++; if (rx_rdy_si !== 1'b1) begin errors++; $display("FAIL bp_rx_first rdy got %b expected 1", rx_rdy_si); end
    low = 0;
    for (int i = 0; i < 30; i++) begin
      if (rx_245 === 1'b0) low++;
      tick();
    end
    checks++; if (low != 0) begin errors++; $display("FAIL bp_rx_hold rd_low_cycles=%0d expected 0", low); end
    rx_data_245 = 8'hC3;
    rx_q.push_back(8'hC3);
    rx_ack_si = 1'b1;
    tick();
    rx_ack_si = 1'b0;
    for (n = 0; n < 40 && rx_rdy_si !== 1'b1; n++) tick();
    checks++; if (rx_rdy_si !== 1'b1) begin errors++; $display("FAIL bp_rx_resume rdy got %b expected 1", rx_rdy_si); end
    rxf_245 = 1'b1;
    repeat (5) tick();
    rx_ack_si = 1'b1;
    tick();
    rx_ack_si = 1'b0;
    repeat (8) tick();
    checks++; if (rx_rdy_si !== 1'b0) begin errors++; $display("FAIL bp_rx_end rdy got %b expected 0", rx_rdy_si); end
  endtask

  task automatic test_tx_backpressure();
    int acks, wrs;
    txe_245    = 1'b1;
    tx_data_si = 8'h77;
    tx_rdy_si  = 1'b1;
    acks = 0; wrs = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx_ack_si === 1'b1) acks++;
      if (wr_245 === 1'b1) wrs++;
      tick();
    end
    checks++; if (acks != 0 || wrs != 0) begin
      errors++; $display("FAIL bp_tx acks=%0d wr_cycles=%0d expected 0 and 0", acks, wrs);
    end
    tx_rdy_si = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_read();
    int n;
    rx_data_245 = 8'hEE;
    rxf_245 = 1'b0;
    for (n = 0; n < 20 && rx_245 !== 1'b0; n++) tick();
    checks++; if (rx_245 !== 1'b0) begin errors++; $display("FAIL midrst_start rx_245 got %b expected 0", rx_245); end
    tick();
    tick();
    rst = 1'b1;
    rxf_245 = 1'b1;
    tick();
    checks++; if (rx_245 !== 1'b1 || rx_rdy_si !== 1'b0) begin
      errors++; $display("FAIL midrst_abort rx_245=%b rdy=%b expected 1 and 0", rx_245, rx_rdy_si);
    end
    rst = 1'b0;
    repeat (10) tick();
    checks++; if (rx_rdy_si !== 1'b0 || rx_data_si !== 8'h00 || rx_245 !== 1'b1 || tx_oe_245 !== 1'b0) begin
      errors++; $display("FAIL midrst_idle rdy=%b data=%h rx_245=%b oe=%b expected 0 00 1 0",
                         rx_rdy_si, rx_data_si, rx_245, tx_oe_245);
    end
  endtask

  task automatic test_contention();
    byte order[$];
    byte exp_order[4];
    int  nr, nw;
    logic prev_rx;
    exp_order[0] = "R"; exp_order[1] = "W"; exp_order[2] = "R"; exp_order[3] = "W";
    nr = 0; nw = 0; prev_rx = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    rx_data_245 = 8'h10;
    tx_data_si  = 8'h20;
    tx_q.push_back(8'h20);
    tx_rdy_si = 1'b1;
    rxf_245   = 1'b0;
    txe_245   = 1'b0;
    for (int c = 0; c < 150; c++) begin
      if (prev_rx && rx_245 === 1'b0) begin
        order.push_back("R");
        rx_q.push_back(rx_data_245);
        nr++;
        if (nr == 2) rxf_245 = 1'b1;
      end
      prev_rx = rx_245;
      if (rx_rdy_si === 1'b1) begin
        rx_ack_si   = 1'b1;
        rx_data_245 = rx_data_245 + 8'h01;
      end else begin
        rx_ack_si = 1'b0;
      end
      if (tx_ack_si === 1'b1) begin
        order.push_back("W");
        nw++;
        if (nw == 1) begin
          tx_data_si = 8'h21;
          tx_q.push_back(8'h21);
        end else begin
          tx_rdy_si = 1'b0;
        end
      end
      tick();
    end
    rx_ack_si = 1'b0;
    txe_245   = 1'b1;
    checks++; if (order.size() != 4) begin errors++; $display("FAIL contention_count got %0d expected 4", order.size()); end
    for (int i = 0; i < 4 && i < order.size(); i++) begin
      checks++;
      if (order[i] !== exp_order[i]) begin
        errors++; $display("FAIL contention_order[%0d] got %c expected %c", i, order[i], exp_order[i]);
      end
    end
    checks++; if (rx_q.size() != 0 || tx_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain rx_left=%0d tx_left=%0d expected 0 and 0", rx_q.size(), tx_q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    test_reset();
    test_read();
    test_write();
    test_rx_backpressure();
    test_tx_backpressure();
    test_reset_mid_read();
    test_contention();
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ft245_interface.md
FT245_INTERFACE -- requirements
Module: ft245_interface

Interface
REQ-001 SHALL have parameter CLOCK_PERIOD_NS, default 10, meaning clk period in ns, used to derive all FT245 strobe timings.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning width of the byte path; fixed at 8.
REQ-003 clk  in  1  system clock; one clock domain; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 rx_data_245  in  8  FT245 data bus, read direction.
REQ-006 rxf_245  in  1  FT245 RXF#, asynchronous, low = byte available.
REQ-007 rx_245  out  1  FT245 RD#, active-low read strobe.
REQ-008 tx_data_245  out  8  FT245 data bus, write direction.
REQ-009 txe_245  in  1  FT245 TXE#, asynchronous, low = space available.
REQ-010 wr_245  out  1  FT245 WR, active-high; byte latched by the device on the falling edge.
REQ-011 tx_oe_245  out  1  high = drive tx_data_245 onto the external tristate bus.
REQ-012 rx_data_si  out  8  received byte to the consumer.
REQ-013 rx_rdy_si  out  1  rx_data_si is valid.
REQ-014 rx_ack_si  in  1  consumer has taken the byte.
REQ-015 tx_data_si  in  8  byte to send.
REQ-016 tx_rdy_si  in  1  tx_data_si is valid.
REQ-017 tx_ack_si  out  1  one-cycle pulse: tx_data_si captured.

Function
REQ-018 SHALL derive cycle counts as ceil(ns/CLOCK_PERIOD_NS), minimum 1:
- T_RD = 50 ns
- T_RDREC = 50 ns
- T_SETUP = 20 ns
- T_WR = 50 ns
- T_HOLD = 10 ns
- At default period: 5, 5, 2, 5, 1 cycles.
REQ-019 SHALL pass rxf_245 and txe_245 through 2-flop synchronizers; all decisions SHALL use the synchronized values.
REQ-020 SHALL implement FSM states IDLE, RD_PULSE, RD_RECOVER, WR_SETUP, WR_PULSE, WR_HOLD.
REQ-021 IDLE read condition: rxf synchronized low AND rx_rdy_si low.
REQ-022 IDLE write condition: txe synchronized low AND tx_rdy_si high.
REQ-023 If only one condition holds in IDLE, SHALL start that transfer.
REQ-024 If both conditions hold in IDLE, SHALL serve the direction not served last; a last-served flag SHALL reset to "write", so the first contended transfer is a read.
REQ-025 Read sequence:
- Drive rx_245 low for T_RD cycles.
- On the last cycle, latch rx_data_245 into rx_data_si and set rx_rdy_si.
- Raise rx_245 and stay in RD_RECOVER for T_RDREC cycles.
- Return to IDLE.
REQ-026 rx_rdy_si SHALL stay high with rx_data_si stable until a cycle with rx_ack_si high; it SHALL clear on the following edge.
REQ-027 rx_ack_si while rx_rdy_si is low SHALL be ignored.
REQ-028 Write sequence:
- On leaving IDLE, register tx_data_si into tx_data_245, pulse tx_ack_si for exactly one cycle, and raise tx_oe_245.
- Hold T_SETUP cycles.
- Assert wr_245 for T_WR cycles.
- Drop wr_245 and keep data and tx_oe_245 for T_HOLD cycles.
- Drop tx_oe_245 and return to IDLE.
REQ-029 tx_data_245 SHALL remain stable from WR_SETUP until tx_oe_245 falls.
REQ-030 tx_oe_245 SHALL never be high during a read.
REQ-031 rx_245 low and tx_oe_245 high SHALL be mutually exclusive.
REQ-032 A source SHALL hold tx_rdy_si and tx_data_si until tx_ack_si.
REQ-033 tx_ack_si SHALL be issued at most once per byte.
REQ-034 Changes of rxf_245 or txe_245 during an active transfer SHALL not abort it.

Reset
REQ-035 On rst, SHALL enter IDLE.
REQ-036 On rst, outputs SHALL take these values:
- rx_245=1, wr_245=0, tx_oe_245=0
- tx_data_245=0, rx_data_si=0
- rx_rdy_si=0, tx_ack_si=0
REQ-037 On rst, synchronizers SHALL be set to 1 and counters cleared.
REQ-038 Reset mid-transfer SHALL abort it on the next edge and discard the byte.

Structure
REQ-039 A shared package SHALL hold the ns timing constants (50/50/20/50/10), the state enum, and the ceil-divide function.
REQ-040 One sub-module SHALL be used: sync_2ff, a 1-bit two-flop synchronizer, instantiated twice.
REQ-041 The FSM and timing counter SHALL live in ft245_interface.

Verification
REQ-042 Read: rxf_245=0, rx_data_245=0xA5 -> rx_245 low exactly 5 cycles, then rx_rdy_si=1 with rx_data_si=0xA5, held until a rx_ack_si pulse, cleared next cycle.
REQ-043 Write: txe_245=0, tx_rdy_si=1, tx_data_si=0x3C -> tx_ack_si pulses 1 cycle, tx_oe_245 rises, 2 cycles later wr_245 high 5 cycles, tx_data_245=0x3C throughout, tx_oe_245 falls 1 cycle after wr_245.
REQ-044 Backpressure (read): rx_rdy_si held high (no ack), rxf_245=0 -> rx_245 stays 1.
REQ-045 Backpressure (write): txe_245=1, tx_rdy_si=1 -> no tx_ack_si, wr_245 stays 0.
REQ-046 Contention: both pending continuously -> transfers alternate read, write, read, write; tx_oe_245 never high while rx_245=0.
REQ-047 Reset mid-read: assert rst on the 3rd RD-low cycle -> next edge rx_245=1, rx_rdy_si=0, FSM IDLE.
